// File: rtl/sga_step_sequencer_if.sv
// -----------------------------------------------------------------------------
// sga_step_sequencer_if
// Bundles the signals between the snake step sequencer, the game UC and the
// SGA_FD datapath.
//
//   UC -> sequencer      : enable, pause
//   player -> sequencer  : buttons (one-hot direction request)
//   datapath -> seq.     : size, is_at_apple, is_at_border, is_at_body,
//                          render_finish
//   sequencer -> datapath: direction, load_head, register_apple, count_size,
//                          render_clr, render_count
//   sequencer -> UC      : step_done, hit, db_state
//
// Modports: master = the sequencer, slave = the UC/datapath side.
//
// Signalling: there is no valid/ready handshake on this bus. Every command
// output is a single-cycle pulse that the datapath acts on at the next rising
// clock edge, with no acknowledge. render_count is the one exception: it stays
// high for as long as the datapath holds render_finish low during the render
// loop, and the datapath shifts one body segment per high cycle.
// -----------------------------------------------------------------------------
interface sga_step_sequencer_if;
  logic       enable;
  logic       pause;
  logic [3:0] buttons;
  logic [3:0] size;
  logic       is_at_apple;
  logic       is_at_border;
  logic       is_at_body;
  logic       render_finish;
  logic [1:0] direction;
  logic       load_head;
  logic       register_apple;
  logic       count_size;
  logic       render_clr;
  logic       render_count;
  logic       step_done;
  logic       hit;
  logic [3:0] db_state;

  modport master (
    input  enable, pause, buttons, size, is_at_apple, is_at_border,
           is_at_body, render_finish,
    output direction, load_head, register_apple, count_size, render_clr,
           render_count, step_done, hit, db_state
  );

  modport slave (
    output enable, pause, buttons, size, is_at_apple, is_at_border,
           is_at_body, render_finish,
    input  direction, load_head, register_apple, count_size, render_clr,
           render_count, step_done, hit, db_state
  );
endinterface

// File: rtl/sga_step_sequencer.sv
// -----------------------------------------------------------------------------
// sga_step_sequencer
// Per-move controller for the Snake Game Arcade datapath. It generates the
// play-time tick, filters the player's direction requests, and sequences one
// snake step per tick: head load, collision check, optional growth, then the
// body-shift render loop.
//
// Ports
//   clock      : system clock, rising edge
//   restart_n  : asynchronous active-low reset
//   bus        : sga_step_sequencer_if.master (control, flags, pulses, debug)
//
// Parameters
//   TICK_CYCLES : unpaused clock cycles between snake steps (>= 2)
//   MAX_SIZE    : largest snake size; growth is suppressed at this value
// -----------------------------------------------------------------------------
module sga_step_sequencer #(
  parameter int TICK_CYCLES = 25000000,
  parameter int MAX_SIZE    = 15
) (
  input  logic                 clock,
  input  logic                 restart_n,
  sga_step_sequencer_if.master bus
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_CYCLES - 1);
  localparam logic [3:0]    MAX_SIZE_V = 4'(MAX_SIZE);

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_WAIT_TICK   = 4'd1;
  localparam logic [3:0] S_LATCH_DIR   = 4'd2;
  localparam logic [3:0] S_LOAD_HEAD   = 4'd3;
  localparam logic [3:0] S_CHECK       = 4'd4;
  localparam logic [3:0] S_GROW        = 4'd5;
  localparam logic [3:0] S_RENDER_INIT = 4'd6;
  localparam logic [3:0] S_RENDER      = 4'd7;
  localparam logic [3:0] S_DONE        = 4'd8;
  localparam logic [3:0] S_HIT         = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dir_q, dir_d;
  logic [1:0]    pend_q, pend_d;
  logic          grow_ok_q, grow_ok_d;

  // One-hot button decode. Direction code: 00=right 01=down 10=left 11=up,
  // so the opposite of any direction is that code with bit 1 flipped.
  logic [1:0] req_dir;
  logic       req_onehot;
  logic       req_accept;

  always_comb begin
    req_dir    = 2'b00;
    req_onehot = 1'b0;
    case (bus.buttons)
      4'b0001: begin req_dir = 2'b00; req_onehot = 1'b1; end
      4'b0010: begin req_dir = 2'b01; req_onehot = 1'b1; end
      4'b0100: begin req_dir = 2'b10; req_onehot = 1'b1; end
      4'b1000: begin req_dir = 2'b11; req_onehot = 1'b1; end
      default: begin req_dir = 2'b00; req_onehot = 1'b0; end
    endcase
  end

  // A request is rejected if it reverses the direction being travelled or
  // the one already queued for the next step. Checking the queued value too
  // stops "up then down" within one tick from undoing the earlier turn, and
  // checking the travelled one keeps a two-press sequence from producing a
  // 180-degree turn into the body.
  assign req_accept = req_onehot
                   && (req_dir != (dir_q  ^ 2'b10))
                   && (req_dir != (pend_q ^ 2'b10));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    grow_ok_d = grow_ok_q;

    if ((state_q != S_IDLE) && req_accept) begin
      pend_d = req_dir;
    end

    if (!bus.enable) begin
      // UC left play state: abandon whatever step is in flight.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_TICK;
          cnt_d   = '0;
        end
        S_WAIT_TICK: begin
          if (!bus.pause) begin
            if (cnt_q == TICK_LAST) begin
              state_d = S_LATCH_DIR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_LATCH_DIR: begin
          dir_d   = pend_q;
          state_d = S_LOAD_HEAD;
        end
        S_LOAD_HEAD: state_d = S_CHECK;
        S_CHECK: begin
          // Capture the size test here so count_size is a pure state decode.
          grow_ok_d = (bus.size < MAX_SIZE_V);
          if (bus.is_at_border || bus.is_at_body) begin
            state_d = S_HIT;
          end else if (bus.is_at_apple) begin
            state_d = S_GROW;
          end else begin
            state_d = S_RENDER_INIT;
          end
        end
        S_GROW:        state_d = S_RENDER_INIT;
        S_RENDER_INIT: state_d = S_RENDER;
        S_RENDER: begin
          if (bus.render_finish) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_WAIT_TICK;
          cnt_d   = '0;
        end
        S_HIT:   state_d = S_HIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dir_q     <= 2'b00;
      pend_q    <= 2'b00;
      grow_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      grow_ok_q <= grow_ok_d;
    end
  end

  // Outputs are decoded from registered state; render_count is the only one
  // that also looks at an input, so the loop stops on the finishing cycle.
  assign bus.direction      = dir_q;
  assign bus.load_head      = (state_q == S_LOAD_HEAD);
  assign bus.register_apple = (state_q == S_GROW);
  assign bus.count_size     = (state_q == S_GROW) && grow_ok_q;
  assign bus.render_clr     = (state_q == S_RENDER_INIT);
  assign bus.render_count   = (state_q == S_RENDER) && !bus.render_finish;
  assign bus.step_done      = (state_q == S_DONE);
  assign bus.hit            = (state_q == S_HIT);
  assign bus.db_state       = state_q;

endmodule

// File: tb/tb_sga_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sga_step_sequencer
// Bench for sga_step_sequencer with TICK_CYCLES=4. A small datapath model
// supplies render_finish; expected command pulses are queued per step and
// popped by a pulse monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_sga_step_sequencer;

  localparam int TICK = 4;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LATCH  = 4'd2;
  localparam logic [3:0] S_RENDER = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;
  localparam logic [3:0] S_HIT    = 4'd9;

  localparam logic [7:0] EV_LOAD  = 8'd1;
  localparam logic [7:0] EV_APPLE = 8'd2;
  localparam logic [7:0] EV_COUNT = 8'd3;
  localparam logic [7:0] EV_CLR   = 8'd4;
  localparam logic [7:0] EV_CNT   = 8'd5;
  localparam logic [7:0] EV_DONE  = 8'd6;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic restart_n;
  always #5 clock = ~clock;

  sga_step_sequencer_if bus();

  sga_step_sequencer #(
    .TICK_CYCLES(TICK),
    .MAX_SIZE   (15)
  ) dut (
    .clock    (clock),
    .restart_n(restart_n),
    .bus      (bus)
  );

  // ---------------- datapath model ----------------
  int         render_len = 0;
  logic [3:0] rcnt = 4'd0;

  always @(posedge clock) begin
    if (bus.render_clr)        rcnt <= 4'd0;
    else if (bus.render_count) rcnt <= rcnt + 4'd1;
  end

  assign bus.render_finish = (rcnt == render_len[3:0]);

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic see_evt(input logic [7:0] code);
    if (exp_q.size() == 0) check_val("unexpected_pulse", {24'd0, code}, 32'd0);
    else                   check_val("pulse_order", {24'd0, code}, {24'd0, exp_q.pop_front()});
  endtask

  always @(negedge clock) begin
    if (bus.load_head)      see_evt(EV_LOAD);
    if (bus.register_apple) see_evt(EV_APPLE);
    if (bus.count_size)     see_evt(EV_COUNT);
    if (bus.render_clr)     see_evt(EV_CLR);
    if (bus.render_count)   see_evt(EV_CNT);
    if (bus.step_done)      see_evt(EV_DONE);
  end

  function automatic logic [5:0] pulses();
    return {bus.load_head, bus.register_apple, bus.count_size,
            bus.render_clr, bus.render_count, bus.step_done};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge with the DUT in IDLE(enable just raised) or DONE.
  // b1/b2 are presented on the first two cycles; pause rises pause_at cycles
  // in and is held for pause_len cycles. exp_lat is the number of cycles
  // until LATCH_DIR is observed.
  task automatic do_step(input string name, input logic [3:0] b1,
                         input logic [3:0] b2, input bit apple, input bit border,
                         input logic [3:0] sz, input int rlen,
                         input int pause_at, input int pause_len,
                         input bit stop_in_render, input logic [1:0] exp_dir,
                         input int exp_lat);
    int n;
    bit seen;
    logic [3:0] target;
    bus.is_at_apple  = apple;
    bus.is_at_border = border;
    bus.is_at_body   = 1'b0;
    bus.size         = sz;
    render_len       = rlen;

    exp_q.push_back(EV_LOAD);
    if (!border) begin
      if (apple) begin
        exp_q.push_back(EV_APPLE);
        if (sz != 4'd15) exp_q.push_back(EV_COUNT);
      end
      exp_q.push_back(EV_CLR);
      if (stop_in_render) begin
        exp_q.push_back(EV_CNT);
      end else begin
        repeat (rlen) exp_q.push_back(EV_CNT);
        exp_q.push_back(EV_DONE);
      end
    end

    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clock);
      #1;
      n++;
      if (n == 1)      bus.buttons = b1;
      else if (n == 2) bus.buttons = b2;
      else             bus.buttons = 4'b0000;
      if (pause_at != 0) begin
        if (n == pause_at)             bus.pause = 1'b1;
        if (n == pause_at + pause_len) bus.pause = 1'b0;
      end
      @(negedge clock);
      if (bus.db_state == S_LATCH) seen = 1'b1;
    end
    bus.pause = 1'b0;
    check_val({name, "_latch_cycle"}, n, exp_lat);

    target = stop_in_render ? S_RENDER : (border ? S_HIT : S_DONE);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clock);
      n++;
      if (bus.db_state == target) seen = 1'b1;
    end
    check_val({name, "_end_state"}, {28'd0, bus.db_state}, {28'd0, target});
    check_val({name, "_direction"}, {30'd0, bus.direction}, {30'd0, exp_dir});
    #1;
    check_val({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    restart_n        = 1'b0;
    bus.enable       = 1'b0;
    bus.pause        = 1'b0;
    bus.buttons      = 4'b0000;
    bus.size         = 4'd0;
    bus.is_at_apple  = 1'b0;
    bus.is_at_border = 1'b0;
    bus.is_at_body   = 1'b0;

    @(negedge clock);
    check_val("reset_state",  {28'd0, bus.db_state},  32'd0);
    check_val("reset_dir",    {30'd0, bus.direction}, 32'd0);
    check_val("reset_hit",    {31'd0, bus.hit},       32'd0);
    check_val("reset_pulses", {26'd0, pulses()},      32'd0);
    restart_n = 1'b1;
    @(negedge clock);
    bus.enable = 1'b1;

    //       name          b1       b2       app bor sz  rl pa pl stop dir    lat
    do_step("basic",       4'b0000, 4'b0000, 0,  0,  3,  3, 0, 0, 0,   2'b00, 5);
    do_step("period",      4'b0100, 4'b0000, 0,  0,  3,  3, 0, 0, 0,   2'b00, 5);
    do_step("up_down",     4'b1000, 4'b0010, 0,  0,  3,  3, 0, 0, 0,   2'b11, 5);
    do_step("multi_hot",   4'b0011, 4'b0000, 0,  0,  3,  3, 0, 0, 0,   2'b11, 5);
    do_step("apple_grow",  4'b0001, 4'b0000, 1,  0,  3,  4, 0, 0, 0,   2'b00, 5);
    do_step("apple_max",   4'b0000, 4'b0000, 1,  0,  15, 2, 0, 0, 0,   2'b00, 5);
    do_step("render_zero", 4'b0010, 4'b0000, 0,  0,  3,  0, 0, 0, 0,   2'b01, 5);
    do_step("collision",   4'b0000, 4'b0000, 1,  1,  3,  3, 0, 0, 0,   2'b01, 5);

    repeat (3) @(negedge clock);
    check_val("hit_held_state", {28'd0, bus.db_state}, {28'd0, S_HIT});
    check_val("hit_held_flag",  {31'd0, bus.hit},      32'd1);
    bus.enable = 1'b0;
    @(negedge clock);
    check_val("hit_exit_state", {28'd0, bus.db_state},  {28'd0, S_IDLE});
    check_val("hit_exit_flag",  {31'd0, bus.hit},       32'd0);
    check_val("hit_exit_dir",   {30'd0, bus.direction}, 32'd1);

    bus.enable = 1'b1;
    do_step("pause",       4'b0000, 4'b0000, 0,  0,  3,  2, 3, 10, 0,  2'b01, 15);
    do_step("abort",       4'b0000, 4'b0000, 0,  0,  3,  5, 0, 0,  1,  2'b01, 5);
    bus.enable = 1'b0;
    @(negedge clock);
    check_val("abort_state", {28'd0, bus.db_state}, {28'd0, S_IDLE});
    repeat (8) @(negedge clock);
    check_val("abort_stays_idle", {28'd0, bus.db_state}, {28'd0, S_IDLE});

    bus.enable = 1'b1;
    do_step("pre_reset",   4'b0100, 4'b0000, 0,  0,  3,  5, 0, 0,  1,  2'b10, 5);
    #2;
    restart_n = 1'b0;
    #1;
    check_val("async_state",  {28'd0, bus.db_state},  32'd0);
    check_val("async_dir",    {30'd0, bus.direction}, 32'd0);
    check_val("async_hit",    {31'd0, bus.hit},       32'd0);
    check_val("async_pulses", {26'd0, pulses()},      32'd0);
    bus.enable = 1'b0;
    @(negedge clock);
    restart_n = 1'b1;
    @(negedge clock);
    bus.enable = 1'b1;
    do_step("post_reset",  4'b0000, 4'b0000, 0,  0,  3,  1, 0, 0,  0,  2'b00, 5);

    check_val("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
